// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared constants for the pipeline hazard/forwarding controller.
//   FWD_* are the execute-stage operand-mux selects:
//     FWD_REG : operand comes from the register file read in decode
//     FWD_WB  : operand forwarded from the writeback-stage result
//     FWD_MEM : operand forwarded from the memory-stage ALU result
package hazard_pkg;

  localparam int DEFAULT_REG_AW = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage : hazard_pkg

// File: rtl/hazard_scoreboard_sat_counter.sv
// sat_counter
//   Saturating up-counter used for hazard performance events.
//   Ports:
//     clk   : clock
//     rst   : asynchronous active-high reset, clears the count
//     inc   : count one event this cycle
//     count : current value, holds at 2**CNT_W-1 once reached
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;

  // Event counter, stops at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= {CNT_W{1'b0}};
    end else if (inc && (r_count != CNT_MAX)) begin
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign count = r_count;

endmodule : sat_counter

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Hazard/forwarding controller for a 5-stage pipeline: operand forwarding,
//   load-use stall, branch flush, a register scoreboard for a variable-latency
//   multi-cycle unit, and saturating stall/flush event counters.
//   Ports:
//     clk, rst                 : clock, asynchronous active-high reset
//     rs1_d/rs2_d/rd_d, use_*, regwrite_d, mc_d : decode-stage instruction
//     rs1_e/rs2_e/rd_e, load_e, pcsrc_e         : execute-stage instruction
//     rd_m/regwrite_m, rd_w/regwrite_w          : later-stage writers
//     mc_done, mc_rd           : multi-cycle unit completion
//     forward_ae/forward_be    : execute operand-mux selects
//     stall_f/stall_d, flush_d/flush_e : pipeline register controls
//     pending, out_cnt         : scoreboard bits and in-flight count
//     stall_cnt, flush_cnt     : saturating event counters
//     sb_err                   : sticky, completion for a non-pending register
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW   = DEFAULT_REG_AW,
  parameter int MAX_OUT  = 4,
  parameter int CNT_W    = 16,
  parameter int NUM_REGS = 2**REG_AW,
  parameter int OC_W     = $clog2(MAX_OUT+1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_AW-1:0]   rs1_d,
  input  logic [REG_AW-1:0]   rs2_d,
  input  logic [REG_AW-1:0]   rd_d,
  input  logic                use_rs1_d,
  input  logic                use_rs2_d,
  input  logic                regwrite_d,
  input  logic                mc_d,
  input  logic [REG_AW-1:0]   rs1_e,
  input  logic [REG_AW-1:0]   rs2_e,
  input  logic [REG_AW-1:0]   rd_e,
  input  logic                load_e,
  input  logic                pcsrc_e,
  input  logic [REG_AW-1:0]   rd_m,
  input  logic                regwrite_m,
  input  logic [REG_AW-1:0]   rd_w,
  input  logic                regwrite_w,
  input  logic                mc_done,
  input  logic [REG_AW-1:0]   mc_rd,
  output logic [1:0]          forward_ae,
  output logic [1:0]          forward_be,
  output logic                stall_f,
  output logic                stall_d,
  output logic                flush_d,
  output logic                flush_e,
  output logic [NUM_REGS-1:0] pending,
  output logic [OC_W-1:0]     out_cnt,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt,
  output logic                sb_err
);

  localparam logic [REG_AW-1:0]   REG_ZERO  = {REG_AW{1'b0}};
  localparam logic [OC_W-1:0]     OC_MAX    = OC_W'(MAX_OUT);
  localparam logic [OC_W-1:0]     OC_ONE    = {{(OC_W-1){1'b0}}, 1'b1};
  localparam logic [NUM_REGS-1:0] ONE_HOT_0 = {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [NUM_REGS-1:0] r_pending;
  logic [OC_W-1:0]     r_out_cnt;
  logic                r_sb_err;

  logic [1:0]          w_fwd_a;
  logic [1:0]          w_fwd_b;
  logic                w_lw_stall;
  logic                w_sb_stall;
  logic                w_stall;
  logic                w_issue;
  logic                w_clr_valid;
  logic                w_clr_bad;
  logic [NUM_REGS-1:0] w_set_vec;
  logic [NUM_REGS-1:0] w_clr_vec;

  // Memory stage wins over writeback because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs_e,
    input logic [REG_AW-1:0] rd_mem,
    input logic              we_mem,
    input logic [REG_AW-1:0] rd_wb,
    input logic              we_wb
  );
    logic [1:0] sel;
    if (we_mem && (rd_mem != REG_ZERO) && (rd_mem == rs_e)) begin
      sel = FWD_MEM;
    end else if (we_wb && (rd_wb != REG_ZERO) && (rd_wb == rs_e)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

  // Operand forwarding selects
  always_comb begin
    w_fwd_a = fwd_sel(rs1_e, rd_m, regwrite_m, rd_w, regwrite_w);
    w_fwd_b = fwd_sel(rs2_e, rd_m, regwrite_m, rd_w, regwrite_w);
  end

  // Stall sources; the scoreboard is read from registered state only, so a
  // completion is visible to decode one cycle later.
  always_comb begin
    w_lw_stall = load_e && (rd_e != REG_ZERO) &&
                 ((use_rs1_d && (rs1_d == rd_e)) || (use_rs2_d && (rs2_d == rd_e)));
    w_sb_stall = (use_rs1_d && r_pending[rs1_d]) ||
                 (use_rs2_d && r_pending[rs2_d]) ||
                 (regwrite_d && (rd_d != REG_ZERO) && r_pending[rd_d]) ||
                 (mc_d && (r_out_cnt == OC_MAX));
    // A taken branch squashes decode, so there is nothing left to hold.
    w_stall    = (w_lw_stall || w_sb_stall) && !pcsrc_e;
    w_issue    = mc_d && regwrite_d && (rd_d != REG_ZERO) && !w_stall && !pcsrc_e;
  end

  // Scoreboard set/clear vectors for the next edge
  always_comb begin
    w_clr_valid = mc_done && (mc_rd != REG_ZERO) && r_pending[mc_rd];
    w_clr_bad   = mc_done && (mc_rd != REG_ZERO) && !r_pending[mc_rd];
    if (w_issue) begin
      w_set_vec = ONE_HOT_0 << rd_d;
    end else begin
      w_set_vec = {NUM_REGS{1'b0}};
    end
    if (w_clr_valid) begin
      w_clr_vec = ONE_HOT_0 << mc_rd;
    end else begin
      w_clr_vec = {NUM_REGS{1'b0}};
    end
  end

  // Pending bits: set wins over clear on the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= {NUM_REGS{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
    end
  end

  // In-flight count tracked incrementally alongside the pending bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_cnt <= {OC_W{1'b0}};
    end else begin
      case ({w_issue, w_clr_valid})
        2'b10:   r_out_cnt <= r_out_cnt + OC_ONE;
        2'b01:   r_out_cnt <= r_out_cnt - OC_ONE;
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // Sticky error for a completion that names a non-pending register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if (w_clr_bad) begin
      r_sb_err <= 1'b1;
    end else begin
      r_sb_err <= r_sb_err;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (w_stall),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pcsrc_e),
    .count (flush_cnt)
  );

  // Control outputs are forced quiet while reset is held
  always_comb begin
    if (rst) begin
      forward_ae = FWD_REG;
      forward_be = FWD_REG;
      stall_f    = 1'b0;
      stall_d    = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
    end else begin
      forward_ae = w_fwd_a;
      forward_be = w_fwd_b;
      stall_f    = w_stall;
      stall_d    = w_stall;
      flush_d    = pcsrc_e;
      flush_e    = pcsrc_e || w_stall;
    end
  end

  assign pending = r_pending;
  assign out_cnt = r_out_cnt;
  assign sb_err  = r_sb_err;

endmodule : hazard_scoreboard

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor hazard/forwarding controller for the 5-stage pipeline (fetch/decode/execute/memory/writeback).
- Adds to the existing forwarding/stall logic:
  - load-use stall,
  - branch flush,
  - a register scoreboard for a variable-latency multi-cycle unit (MUL/DIV),
  - saturating hazard performance counters.
- Sits beside the pipeline stages and drives stall/flush/forward controls to the fetch, decode and execute stages.

Parameters:
- REG_AW, 5, register-index width; NUM_REGS = 2**REG_AW; register 0 is hardwired zero.
- MAX_OUT, 4, maximum multi-cycle writes in flight (1..NUM_REGS-1).
- CNT_W, 16, performance-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- rs1_d, rs2_d, rd_d  in  REG_AW  decode-stage source and destination indices.
- use_rs1_d, use_rs2_d  in  1  decode instruction actually reads rs1/rs2.
- regwrite_d  in  1  decode instruction writes rd_d.
- mc_d  in  1  decode instruction is a multi-cycle op.
- rs1_e, rs2_e, rd_e  in  REG_AW  execute-stage indices.
- load_e  in  1  execute instruction is a load (result comes from memory).
- pcsrc_e  in  1  taken branch/jump resolved in execute.
- rd_m  in  REG_AW  memory-stage destination index.
- regwrite_m  in  1  memory-stage write enable.
- rd_w  in  REG_AW  writeback-stage destination index.
- regwrite_w  in  1  writeback-stage write enable.
- mc_done  in  1  multi-cycle unit completes and writes mc_rd this cycle.
- mc_rd  in  REG_AW  destination of the completing multi-cycle op.
- forward_ae, forward_be  out  2  execute operand-mux selects.
- stall_f, stall_d  out  1  hold the fetch/decode registers.
- flush_d, flush_e  out  1  clear the decode/execute registers.
- pending  out  NUM_REGS  scoreboard bit vector.
- out_cnt  out  $clog2(MAX_OUT+1)  multi-cycle ops in flight.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.
- sb_err  out  1  sticky error: mc_done named a register that was not pending.

Behaviour:
- Reset (asynchronous, rst=1): pending=0, out_cnt=0, counters=0, sb_err=0.
- Combinational outputs while rst=1: stall_*=0, flush_*=0, forward_*=2'b00.
- Forwarding, per operand, combinational:
  - 2'b10 if regwrite_m && rd_m!=0 && rd_m==rs_e;
  - else 2'b01 if regwrite_w && rd_w!=0 && rd_w==rs_e;
  - else 2'b00.
  - Memory stage has priority over writeback.
- lw_stall = load_e && rd_e!=0 && ((use_rs1_d && rs1_d==rd_e) || (use_rs2_d && rs2_d==rd_e)).
- sb_stall is asserted when any of the following holds:
  - (use_rs1_d && pending[rs1_d]) || (use_rs2_d && pending[rs2_d]) (RAW);
  - regwrite_d && rd_d!=0 && pending[rd_d] (WAW);
  - mc_d && out_cnt==MAX_OUT (structural).
- Scoreboard timing: pending is read from registered state only. An mc_done in cycle N releases the stall in cycle N+1; no same-cycle bypass.
- stall = (lw_stall || sb_stall) && !pcsrc_e. A branch squashes the decode instruction, so the stall is dropped.
- Control outputs:
  - stall_f = stall_d = stall.
  - flush_d = pcsrc_e.
  - flush_e = pcsrc_e || stall.
- issue = mc_d && regwrite_d && rd_d!=0 && !stall && !pcsrc_e.
  - On issue, set pending[rd_d] at the next edge.
- On mc_done with mc_rd!=0, clear pending[mc_rd].
  - If that bit was not set: no change and sb_err<=1 (sticky until reset).
  - mc_done with mc_rd==0 is ignored.
- Same register set and cleared in one cycle: set wins.
- out_cnt always equals popcount(pending); it is updated incrementally: +issue, -valid clear, both => unchanged.
- Counters:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle pcsrc_e=1.
  - Both saturate at 2**CNT_W-1.
- Reset asserted mid-operation: in-flight scoreboard state is discarded. The multi-cycle unit must be reset together with this block.

Decomposition:
- Shared package hazard_pkg:
  - forwarding-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - the default REG_AW.
- One sub-module, sat_counter (CNT_W, inc; async reset), instantiated twice for stall_cnt and flush_cnt.
- Forwarding, stall and scoreboard logic live in the top.

Test Plan:
- Forwarding: regwrite_m=1, rd_m=5, regwrite_w=1, rd_w=5, rs1_e=5 -> forward_ae=2'b10. With rd_m=0 -> 2'b01. With rs2_e=0, rd_w=0 -> forward_be=2'b00.
- Load-use: load_e=1, rd_e=7, use_rs2_d=1, rs2_d=7 -> stall_f=stall_d=flush_e=1 for exactly one cycle, and stall_cnt=1 afterwards.
- Scoreboard: issue mc to rd_d=3; next cycle rs1_d=3 -> stall held. mc_done, mc_rd=3 at cycle N -> stall=0 at N+1, pending[3]=0, out_cnt=0.
- Structural (MAX_OUT=4): issue to r1..r4, then a 5th mc_d -> stall=1 until any mc_done. r2 completing -> out_cnt goes 4->3, 5th issues next cycle.
- Branch priority: lw_stall conditions true and pcsrc_e=1 -> stall=0, flush_d=flush_e=1, no issue, flush_cnt increments. Raise flush_cnt to 2**CNT_W-1 -> holds.
- Error/reset: mc_done with mc_rd=9 and pending[9]=0 -> sb_err=1 and stays set. Async rst mid-cycle -> pending=0, sb_err=0, counters=0 immediately, without waiting for a clock edge.
